branch_ctl: RTL and testbench

BRANCH_CTL -- requirements
Module: branch_ctl

---
 rtl/branch_ctl_if.sv | 33 +++
 rtl/branch_ctl.sv | 93 +++++++++
 tb/tb_branch_ctl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/branch_ctl_if.sv
// branch_ctl_if: control-op, flag, LUT-write and jump-result signals between a decoder and branch_ctl
//   master: drives prog_ctr, op_valid, op, lut_idx, flag_we, zero_in, lut_we, lut_waddr, lut_wdata;
//           receives absjump_en, target, stack_depth, stk_ovf, stk_unf
//   slave : the mirror image, used by branch_ctl
interface branch_ctl_if #(
    parameter int D  = 10,
    parameter int SD = 4
);
    logic [D-1:0]           prog_ctr;
    logic                   op_valid;
    logic [2:0]             op;
    logic [3:0]             lut_idx;
    logic                   flag_we;
    logic                   zero_in;
    logic                   lut_we;
    logic [3:0]             lut_waddr;
    logic [D-1:0]           lut_wdata;
    logic                   absjump_en;
    logic [D-1:0]           target;
    logic [$clog2(SD):0]    stack_depth;
    logic                   stk_ovf;
    logic                   stk_unf;

    modport master (
        output prog_ctr, op_valid, op, lut_idx, flag_we, zero_in, lut_we, lut_waddr, lut_wdata,
        input  absjump_en, target, stack_depth, stk_ovf, stk_unf
    );

    modport slave (
        input  prog_ctr, op_valid, op, lut_idx, flag_we, zero_in, lut_we, lut_waddr, lut_wdata,
        output absjump_en, target, stack_depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/branch_ctl.sv
// branch_ctl: branch/jump controller with zero flag, 16-entry target LUT and a call/return stack
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-high reset
//   bus   : branch_ctl_if.slave (op inputs, LUT write port, jump request/target, stack status)
module branch_ctl #(
    parameter int D  = 10,
    parameter int SD = 4
) (
    input  logic            clk,
    input  logic            reset,
    branch_ctl_if.slave     bus
);
    localparam int AW = (SD > 1) ? $clog2(SD) : 1;
    localparam int DW = $clog2(SD) + 1;
    localparam logic [DW-1:0] FULL = DW'(SD);

    logic            z_q, z_d;
    logic [D-1:0]    lut_q [16];
    logic [D-1:0]    lut_d [16];
    logic [D-1:0]    stk_q [SD];
    logic [D-1:0]    stk_d [SD];
    logic [DW-1:0]   depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic            v, is_jmp, is_jz, is_jnz, is_call, is_ret;
    logic            full, empty, call_ok, ret_ok;
    logic [DW-1:0]   top_idx;
    logic [D-1:0]    lut_rd;

    // Reset masks the op so the jump outputs are quiet while reset is held.
    always_comb begin
        v       = bus.op_valid && !reset;
        is_jmp  = v && bus.op == 3'b001;
        is_jz   = v && bus.op == 3'b010;
        is_jnz  = v && bus.op == 3'b011;
        is_call = v && bus.op == 3'b100;
        is_ret  = v && bus.op == 3'b101;
        full    = depth_q == FULL;
        empty   = depth_q == '0;
        call_ok = is_call && !full;
        ret_ok  = is_ret && !empty;
        top_idx = depth_q - DW'(1);
        lut_rd  = lut_q[bus.lut_idx];
    end

    // Jump request is combinational so the PC stage sees it with zero latency;
    // JZ/JNZ always present the LUT target, taken or not.
    always_comb begin
        bus.absjump_en  = is_jmp | (is_jz & z_q) | (is_jnz & ~z_q) | call_ok | ret_ok;
        bus.target      = (is_jmp | is_jz | is_jnz | call_ok) ? lut_rd :
                          ret_ok ? stk_q[top_idx[AW-1:0]] : '0;
        bus.stack_depth = depth_q;
        bus.stk_ovf     = ovf_q;
        bus.stk_unf     = unf_q;
    end

    // LUT writes and stack push/pop are independent; reads use the pre-write LUT.
    always_comb begin
        z_d     = bus.flag_we ? bus.zero_in : z_q;
        lut_d   = lut_q;
        stk_d   = stk_q;
        depth_d = depth_q;
        if (bus.lut_we)
            lut_d[bus.lut_waddr] = bus.lut_wdata;
        if (call_ok) begin
            stk_d[depth_q[AW-1:0]] = bus.prog_ctr + D'(1);
            depth_d                = depth_q + DW'(1);
        end else if (ret_ok) begin
            depth_d = top_idx;
        end
        ovf_d = ovf_q | (is_call & full);
        unf_d = unf_q | (is_ret & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q     <= 1'b0;
            lut_q   <= '{default: '0};
            stk_q   <= '{default: '0};
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            z_q     <= z_d;
            lut_q   <= lut_d;
            stk_q   <= stk_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule

// File: tb/tb_branch_ctl.sv
// tb_branch_ctl: directed vectors with a scoreboard queue checked by an independent monitor
module tb_branch_ctl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    typedef struct {
        string      name;
        logic       en;
        logic [9:0] tgt;
        logic [2:0] dep;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];

    branch_ctl_if #(.D(10), .SD(4)) bus ();
    branch_ctl #(.D(10), .SD(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    localparam logic [2:0] NOP = 3'b000, JMP = 3'b001, JZ = 3'b010, JNZ = 3'b011,
                           CALL = 3'b100, RET = 3'b101;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic idle_in();
        bus.prog_ctr  = '0;
        bus.op_valid  = 1'b0;
        bus.op        = NOP;
        bus.lut_idx   = '0;
        bus.flag_we   = 1'b0;
        bus.zero_in   = 1'b0;
        bus.lut_we    = 1'b0;
        bus.lut_waddr = '0;
        bus.lut_wdata = '0;
    endtask

    // Drive one cycle of stimulus and queue what the outputs must show during it.
    task automatic vec(input string nm, input logic rst, input logic ov, input logic [2:0] o,
                       input logic [3:0] idx, input logic [9:0] pc,
                       input logic fwe, input logic zin,
                       input logic lwe, input logic [3:0] wa, input logic [9:0] wd,
                       input logic e_en, input logic [9:0] e_tgt, input logic [2:0] e_dep,
                       input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        bus.op_valid  = ov;
        bus.op        = o;
        bus.lut_idx   = idx;
        bus.prog_ctr  = pc;
        bus.flag_we   = fwe;
        bus.zero_in   = zin;
        bus.lut_we    = lwe;
        bus.lut_waddr = wa;
        bus.lut_wdata = wd;
        e = '{nm, e_en, e_tgt, e_dep, e_ovf, e_unf};
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".en"},  32'(bus.absjump_en),  32'(e.en));
                chk({e.name, ".tgt"}, 32'(bus.target),      32'(e.tgt));
                chk({e.name, ".dep"}, 32'(bus.stack_depth), 32'(e.dep));
                chk({e.name, ".ovf"}, 32'(bus.stk_ovf),     32'(e.ovf));
                chk({e.name, ".unf"}, 32'(bus.stk_unf),     32'(e.unf));
            end
        end
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        idle_in();
        repeat (2) @(negedge clk);
        //   name       rst ov op    idx  pc      fwe zin lwe wa  wd        en tgt     dep ovf unf
        vec("rst_jmp",  1, 1, JMP,  3, 10'h000, 0, 0, 0, 0, 10'h000,  0, 10'h000, 0, 0, 0);
        vec("lutw3",    0, 1, JMP,  3, 10'h000, 0, 0, 1, 3, 10'h155,  1, 10'h000, 0, 0, 0);
        vec("jmp3",     0, 1, JMP,  3, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h155, 0, 0, 0);
        vec("jz_fwe",   0, 1, JZ,   3, 10'h000, 1, 1, 0, 0, 10'h000,  0, 10'h155, 0, 0, 0);
        vec("jz_take",  0, 1, JZ,   3, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h155, 0, 0, 0);
        vec("jnz_no",   0, 1, JNZ,  3, 10'h000, 0, 0, 0, 0, 10'h000,  0, 10'h155, 0, 0, 0);
        vec("clr_z",    0, 1, NOP,  3, 10'h000, 1, 0, 0, 0, 10'h000,  0, 10'h000, 0, 0, 0);
        vec("jnz_take", 0, 1, JNZ,  3, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h155, 0, 0, 0);
        vec("inval",    0, 0, JMP,  3, 10'h000, 0, 0, 0, 0, 10'h000,  0, 10'h000, 0, 0, 0);
        vec("op110",    0, 1, 3'b110, 3, 10'h000, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0);
        vec("lutw1",    0, 1, NOP,  0, 10'h000, 0, 0, 1, 1, 10'h040,  0, 10'h000, 0, 0, 0);
        vec("call1",    0, 1, CALL, 1, 10'h010, 0, 0, 0, 0, 10'h000,  1, 10'h040, 0, 0, 0);
        vec("call2",    0, 1, CALL, 1, 10'h020, 0, 0, 0, 0, 10'h000,  1, 10'h040, 1, 0, 0);
        vec("call3",    0, 1, CALL, 1, 10'h030, 0, 0, 0, 0, 10'h000,  1, 10'h040, 2, 0, 0);
        vec("call4",    0, 1, CALL, 1, 10'h040, 0, 0, 0, 0, 10'h000,  1, 10'h040, 3, 0, 0);
        vec("call_ovf", 0, 1, CALL, 1, 10'h050, 0, 0, 0, 0, 10'h000,  0, 10'h000, 4, 0, 0);
        vec("ret1",     0, 1, RET,  0, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h041, 4, 1, 0);
        vec("ret2",     0, 1, RET,  0, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h031, 3, 1, 0);
        vec("ret3",     0, 1, RET,  0, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h021, 2, 1, 0);
        vec("ret4",     0, 1, RET,  0, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h011, 1, 1, 0);
        vec("ret_unf",  0, 1, RET,  0, 10'h000, 0, 0, 0, 0, 10'h000,  0, 10'h000, 0, 1, 0);
        for (int i = 0; i < 10; i++)
            vec("idle",  0, 0, NOP,  0, 10'h000, 0, 0, 0, 0, 10'h000,  0, 10'h000, 0, 1, 1);
        vec("call_wrap",0, 1, CALL, 1, 10'h3FF, 0, 0, 0, 0, 10'h000,  1, 10'h040, 0, 1, 1);
        vec("ret_wrap", 0, 1, RET,  0, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h000, 1, 1, 1);
        vec("call_lutw",0, 1, CALL, 2, 10'h100, 0, 0, 1, 2, 10'h2AA,  1, 10'h000, 0, 1, 1);
        vec("call_b",   0, 1, CALL, 2, 10'h200, 0, 0, 0, 0, 10'h000,  1, 10'h2AA, 1, 1, 1);
        vec("rst_mid",  1, 1, RET,  0, 10'h000, 1, 1, 1, 5, 10'h123,  0, 10'h000, 2, 1, 1);
        vec("post_j0",  0, 1, JMP,  0, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h000, 0, 0, 0);
        vec("post_j5",  0, 1, JMP,  5, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h000, 0, 0, 0);
        vec("post_j2",  0, 1, JMP,  2, 10'h000, 0, 0, 0, 0, 10'h000,  1, 10'h000, 0, 0, 0);
        vec("post_jz",  0, 1, JZ,   1, 10'h000, 0, 0, 0, 0, 10'h000,  0, 10'h000, 0, 0, 0);
        vec("post_ret", 0, 1, RET,  0, 10'h000, 0, 0, 0, 0, 10'h000,  0, 10'h000, 0, 0, 0);
        vec("post_unf", 0, 0, NOP,  0, 10'h000, 0, 0, 0, 0, 10'h000,  0, 10'h000, 0, 0, 1);
        @(negedge clk);
        idle_in();
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #3;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
